// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes valid/ready bitstream words LSB-first into a ccff chain; optional readback via CCFF_READBACK_EN.
// Latency: a word accepted in cycle N puts its bit 0 on ccff_head with ccff_shift_en in cycle N+1; consecutive words shift with no bubble.
// Backpressure: cfg_ready is low while bits are pending or the chain is already covered; with readback, an unaccepted rb word stalls shifting.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    input  logic              test_en_req,
    output logic              Test_en,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef CCFF_READBACK_EN
    ,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    input  logic              rb_ready
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BL_W  = $clog2(WORD_W + 1);
    localparam int SUM_W = ((CNT_W > BL_W) ? CNT_W : BL_W) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [BL_W-1:0]   bits_left;

    logic              rb_stall;
    logic              shift_go;
    logic              last_bit;
    logic              accept;
    logic [SUM_W-1:0]  covered;
    logic [SUM_W-1:0]  remaining;
    logic [BL_W-1:0]   load_bits;

    assign busy      = (state == ST_LOAD);
    // covered counts bits already shifted plus bits still queued in shreg
    assign covered   = SUM_W'(bit_cnt) + SUM_W'(bits_left);
    assign remaining = SUM_W'(CHAIN_LEN) - covered;
    assign load_bits = (remaining < SUM_W'(WORD_W)) ? BL_W'(remaining) : BL_W'(WORD_W);

    assign shift_go  = busy && (bits_left != '0) && !abort && !rb_stall;
    assign last_bit  = shift_go && ((SUM_W'(bit_cnt) + SUM_W'(1)) == SUM_W'(CHAIN_LEN));
    assign cfg_ready = busy && !rb_stall
                       && ((bits_left == '0) || ((bits_left == BL_W'(1)) && shift_go))
                       && (covered < SUM_W'(CHAIN_LEN));
    assign accept    = cfg_valid && cfg_ready;

    assign ccff_shift_en = shift_go;
    assign ccff_head     = shift_go ? shreg[0] : 1'b0;
    assign Test_en       = test_en_req & ~busy;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            bits_left <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        bits_left <= '0;
                        done      <= 1'b0;
                        aborted   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        aborted   <= 1'b1;
                        shreg     <= '0;
                        bits_left <= '0;
                    end else begin
                        if (shift_go) begin
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            shreg     <= shreg >> 1;
                            bits_left <= bits_left - BL_W'(1);
                        end
                        // a new word replaces the drained shreg on the same edge
                        if (accept) begin
                            shreg     <= cfg_data;
                            bits_left <= load_bits;
                        end
                        if (last_bit) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_pack;
    logic [WORD_W-1:0] pack_next;
    logic [BL_W-1:0]   rb_cnt;

    assign rb_stall = rb_valid && !rb_ready;

    always_comb begin
        pack_next = rb_pack;
        for (int i = 0; i < WORD_W; i++) begin
            if (rb_cnt == BL_W'(i)) pack_next[i] = ccff_tail;
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            rb_pack  <= '0;
            rb_cnt   <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else if ((!busy && start) || (busy && abort)) begin
            rb_pack  <= '0;
            rb_cnt   <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (rb_valid && rb_ready) rb_valid <= 1'b0;
            // the stall guarantees the previous word has left before a new one lands
            if (shift_go) begin
                if ((rb_cnt == BL_W'(WORD_W - 1)) || last_bit) begin
                    rb_data  <= pack_next;
                    rb_valid <= 1'b1;
                    rb_pack  <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_pack <= pack_next;
                    rb_cnt  <= rb_cnt + BL_W'(1);
                end
            end
        end
    end
`else
    logic unused_tail;

    assign rb_stall    = 1'b0;
    assign unused_tail = ccff_tail;
`endif

endmodule
